wb_arbiter: RTL and testbench

- Writeback arbiter that drives the integer register file write port (rd address, write enable, result).
- Merges two producers:
  - the in-order pipeline result (ALU/load) through a valid/ready handshake;
  - the long-latency multiply/divide unit through a small FIFO.
- Exports a pending-destination mask so the decode-stage hazard logic can stall reads of registers whose writes have not yet landed.

---
 rtl/wb_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges in-order pipeline results with queued MDU results onto
// the single register-file write port and reports which destinations are still in flight.
module wb_arbiter #(
  parameter int REG_WIDTH    = 64,
  parameter int MDU_DEPTH    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_i,
  input  logic                 pipe_valid_i,
  output logic                 pipe_ready_o,
  input  logic [4:0]           pipe_rd_addr_i,
  input  logic [REG_WIDTH-1:0] pipe_result_i,
  input  logic                 mdu_valid_i,
  output logic                 mdu_ready_o,
  input  logic [4:0]           mdu_rd_addr_i,
  input  logic [REG_WIDTH-1:0] mdu_result_i,
  output logic [4:0]           rd_addr_o,
  output logic                 rd_wen_o,
  output logic [REG_WIDTH-1:0] result_o,
  output logic [31:0]          pending_o
);

  localparam int PTR_W = $clog2(MDU_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MDU_DEPTH);
  localparam logic [SC_W-1:0]  LIMIT_C = SC_W'(STARVE_LIMIT);

  logic [4:0]           rd_mem   [MDU_DEPTH];
  logic [REG_WIDTH-1:0] data_mem [MDU_DEPTH];

  logic [PTR_W-1:0] wptr_reg;
  logic [PTR_W-1:0] rptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [SC_W-1:0]  starve_reg;

  logic                 fifo_nonempty;
  logic                 push;
  logic                 pop;
  logic                 pipe_sel;
  logic                 sel_valid;
  logic [4:0]           sel_rd;
  logic [REG_WIDTH-1:0] sel_data;
  logic [31:0]          fifo_mask;
  logic [31:0]          entry_mask [MDU_DEPTH];

  assign fifo_nonempty = (count_reg != '0);
  assign mdu_ready_o   = (count_reg < DEPTH_C);
  assign pipe_ready_o  = !(fifo_nonempty && (starve_reg == LIMIT_C));

  // Writes to x0 are architecturally void, so they never occupy a FIFO slot.
  assign push     = mdu_valid_i && mdu_ready_o && (mdu_rd_addr_i != 5'd0);
  assign pipe_sel = pipe_valid_i && pipe_ready_o;
  assign pop      = !pipe_sel && fifo_nonempty;

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (pipe_sel) begin
      sel_valid = 1'b1;
      sel_rd    = pipe_rd_addr_i;
      sel_data  = pipe_result_i;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = rd_mem[rptr_reg];
      sel_data  = data_mem[rptr_reg];
    end
  end

  // Payload storage carries no reset: occupancy is tracked solely by count_reg.
  always_ff @(posedge clk_sys_i) begin
    if (push) begin
      rd_mem[wptr_reg]   <= mdu_rd_addr_i;
      data_mem[wptr_reg] <= mdu_result_i;
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + PTR_W'(1);
      if (pop)  rptr_reg <= rptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The counter measures how long the current head has waited behind the pipeline.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      starve_reg <= '0;
    end else if (!fifo_nonempty || pop) begin
      starve_reg <= '0;
    end else if (starve_reg != LIMIT_C) begin
      starve_reg <= starve_reg + SC_W'(1);
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      rd_wen_o  <= 1'b0;
      rd_addr_o <= '0;
      result_o  <= '0;
    end else begin
      rd_wen_o <= sel_valid && (sel_rd != 5'd0);
      if (sel_valid) begin
        rd_addr_o <= sel_rd;
        result_o  <= sel_data;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar gi = 0; gi < MDU_DEPTH; gi++) begin : g_entry
    logic [PTR_W-1:0] offset;
    assign offset         = PTR_W'(gi) - rptr_reg;
    assign entry_mask[gi] = ({1'b0, offset} < count_reg) ? (32'h1 << rd_mem[gi]) : 32'h0;
  end

  always_comb begin
    fifo_mask = '0;
    for (int i = 0; i < MDU_DEPTH; i++) begin
      fifo_mask = fifo_mask | entry_mask[i];
    end
  end

  assign pending_o = (fifo_mask | (rd_wen_o ? (32'h1 << rd_addr_o) : 32'h0)) & ~32'h1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, all compared against a
// queue-based model of the writeback rules.
module tb_wb_arbiter;

  localparam int W     = 64;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pipe_valid = 1'b0;
  logic         pipe_ready;
  logic [4:0]   pipe_rd = '0;
  logic [W-1:0] pipe_res = '0;
  logic         mdu_valid = 1'b0;
  logic         mdu_ready;
  logic [4:0]   mdu_rd = '0;
  logic [W-1:0] mdu_res = '0;
  logic [4:0]   rd_addr;
  logic         rd_wen;
  logic [W-1:0] result;
  logic [31:0]  pending;

  always #5 clk = ~clk;

  wb_arbiter #(.REG_WIDTH(W), .MDU_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_sys_i      (clk),
    .rst_i          (rst),
    .pipe_valid_i   (pipe_valid),
    .pipe_ready_o   (pipe_ready),
    .pipe_rd_addr_i (pipe_rd),
    .pipe_result_i  (pipe_res),
    .mdu_valid_i    (mdu_valid),
    .mdu_ready_o    (mdu_ready),
    .mdu_rd_addr_i  (mdu_rd),
    .mdu_result_i   (mdu_res),
    .rd_addr_o      (rd_addr),
    .rd_wen_o       (rd_wen),
    .result_o       (result),
    .pending_o      (pending)
  );

  typedef struct packed {
    logic [4:0]   rd;
    logic [W-1:0] data;
  } ent_t;

  // Reference model: queued MDU results, head wait time, and the expected write port.
  ent_t         q[$];
  int           waited;
  logic         m_wen;
  logic [4:0]   m_addr;
  logic [W-1:0] m_res;
  bit           pipe_took;
  bit           mdu_took;
  logic [4:0]   seen[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_pending();
    logic [31:0] m;
    m = 32'h0;
    foreach (q[i]) m = m | (32'h1 << q[i].rd);
    if (m_wen) m = m | (32'h1 << m_addr);
    return m & ~32'h1;
  endfunction

  task automatic model_reset();
    q.delete();
    waited = 0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_res  = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".wen"},   rd_wen,     m_wen);
    check({tag, ".addr"},  rd_addr,    m_addr);
    check({tag, ".res"},   result,     m_res);
    check({tag, ".pready"}, pipe_ready, !(q.size() != 0 && waited == LIMIT));
    check({tag, ".mready"}, mdu_ready,  q.size() < DEPTH);
    check({tag, ".pend"},  pending,    exp_pending());
  endtask

  task automatic cycle(input string tag,
                       input logic pv, input logic [4:0] prd, input logic [W-1:0] pres,
                       input logic mv, input logic [4:0] mrd, input logic [W-1:0] mres);
    bit   pr, mr, was_empty, pt, mt, pp;
    ent_t e;
    pipe_valid = pv; pipe_rd = prd; pipe_res = pres;
    mdu_valid  = mv; mdu_rd  = mrd; mdu_res  = mres;
    @(posedge clk);
    pr        = !(q.size() != 0 && waited == LIMIT);
    mr        = q.size() < DEPTH;
    was_empty = (q.size() == 0);
    pt        = pv && pr;
    mt        = mv && mr;
    pp        = !pt && !was_empty;
    if (pt) begin
      m_wen = (prd != 5'd0); m_addr = prd; m_res = pres;
    end else if (pp) begin
      e = q.pop_front();
      m_wen = 1'b1; m_addr = e.rd; m_res = e.data;
    end else begin
      m_wen = 1'b0;
    end
    if (was_empty || pp) waited = 0;
    else if (waited < LIMIT) waited++;
    if (mt && mrd != 5'd0) begin
      e.rd = mrd; e.data = mres;
      q.push_back(e);
    end
    pipe_took = pt;
    mdu_took  = mt;
    @(negedge clk);
    if (rd_wen) begin
      seen.push_back(rd_addr);
      $display("[%s] wb rd=x%0d data=%0h", tag, rd_addr, result);
    end
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  logic         r_pv, r_mv;
  logic [4:0]   r_prd, r_mrd;
  logic [W-1:0] r_pres, r_mres;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs("reset");

    // Pipeline only
    cycle("pipe", 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, '0);
    check("pipe.wen5", rd_wen, 1'b1);
    check("pipe.addr5", rd_addr, 5'd5);
    check("pipe.res1234", result, 64'h1234);
    check("pipe.ready", pipe_ready, 1'b1);

    // Zero register from both sources
    cycle("zero", 1'b1, 5'd0, 64'hdead, 1'b0, 5'd0, '0);
    check("zero.pipe_wen", rd_wen, 1'b0);
    cycle("zero", 1'b0, 5'd0, '0, 1'b1, 5'd0, 64'hbeef);
    check("zero.mready", mdu_ready, 1'b1);
    idle("zero");
    check("zero.pend", pending, 32'h0);
    check("zero.wen", rd_wen, 1'b0);

    // Starvation: MDU head waits behind a continuously valid pipeline
    cycle("starve", 1'b1, 5'd9, 64'h99, 1'b1, 5'd7, 64'h77);
    check("starve.pend7_push", pending[7], 1'b1);
    for (int k = 0; k < 2; k++) begin
      cycle("starve", 1'b1, 5'd9, 64'h99, 1'b0, 5'd0, '0);
      check("starve.pready_hi", pipe_ready, 1'b1);
    end
    cycle("starve", 1'b1, 5'd9, 64'h99, 1'b0, 5'd0, '0);
    check("starve.pready_lo", pipe_ready, 1'b0);
    check("starve.pend7_wait", pending[7], 1'b1);
    cycle("starve", 1'b1, 5'd9, 64'h99, 1'b0, 5'd0, '0);
    check("starve.addr7", rd_addr, 5'd7);
    check("starve.res77", result, 64'h77);
    check("starve.pready_back", pipe_ready, 1'b1);
    idle("starve");
    check("starve.pend7_done", pending[7], 1'b0);

    // Fill to full with pipeline holding priority, then drain across pointer wrap
    for (int i = 1; i <= 4; i++)
      cycle("full", 1'b1, 5'd0, '0, 1'b1, 5'(i), 64'(i * 16));
    check("full.mready", mdu_ready, 1'b0);
    check("full.pend", pending, 32'h1E);
    seen.delete();
    idle("drain");
    check("drain.first", rd_addr, 5'd1);
    for (int i = 10; i <= 15; i++)
      cycle("wrap", 1'b0, 5'd0, '0, 1'b1, 5'(i), 64'(i * 256));
    repeat (4) idle("wrap");
    check("wrap.count", seen.size(), 10);
    for (int i = 0; i < seen.size() && i < 10; i++)
      check("wrap.order", seen[i], (i < 4) ? 5'(i + 1) : 5'(i + 6));

    // Simultaneous push and pop at count=2
    cycle("pushpop", 1'b1, 5'd0, '0, 1'b1, 5'd20, 64'h20);
    cycle("pushpop", 1'b1, 5'd0, '0, 1'b1, 5'd21, 64'h21);
    cycle("pushpop", 1'b0, 5'd0, '0, 1'b1, 5'd22, 64'h22);
    check("pushpop.addr20", rd_addr, 5'd20);
    check("pushpop.pend", pending, 32'h0070_0000);
    idle("pushpop");
    check("pushpop.addr21", rd_addr, 5'd21);
    idle("pushpop");
    check("pushpop.addr22", rd_addr, 5'd22);

    // Asynchronous reset with two queued entries and a write in flight
    cycle("arst", 1'b1, 5'd0, '0, 1'b1, 5'd3, 64'h3);
    cycle("arst", 1'b1, 5'd2, 64'hab, 1'b1, 5'd6, 64'h6);
    check("arst.pre_pend", pending, 32'h0000_004C);
    pipe_valid = 1'b0; mdu_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst.wen", rd_wen, 1'b0);
    check("arst.pend", pending, 32'h0);
    check("arst.addr", rd_addr, 5'd0);
    check("arst.pready", pipe_ready, 1'b1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs("arst.post");

    // Random traffic with producers honouring hold-while-not-ready
    r_pv = 1'b0; r_mv = 1'b0;
    r_prd = '0; r_mrd = '0; r_pres = '0; r_mres = '0;
    pipe_took = 1'b1; mdu_took = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (!r_pv || pipe_took) begin
        r_pv   = ($urandom_range(0, 99) < 55);
        r_prd  = 5'($urandom_range(0, 31));
        r_pres = {$urandom, $urandom};
      end
      if (!r_mv || mdu_took) begin
        r_mv   = ($urandom_range(0, 99) < 45);
        r_mrd  = 5'($urandom_range(0, 31));
        r_mres = {$urandom, $urandom};
      end
      cycle("rand", r_pv, r_prd, r_pres, r_mv, r_mrd, r_mres);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
